// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC-style RAM responder: op3 access codes,
// access-size encoding, FSM state type and the op3 decoder.
package sparc_mem_pkg;

  // SPARC op3 codes understood by the responder
  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Decoded view of one op3 code
  typedef struct packed {
    logic  legal;
    logic  store;
    logic  sext;
    size_e size;
  } op_dec_t;

  function automatic op_dec_t decode_op3(input logic [5:0] op3);
    op_dec_t d;
    d.legal = 1'b1;
    d.store = 1'b0;
    d.sext  = 1'b0;
    d.size  = SZ_WORD;
    case (op3)
      OP_LD:   d.size = SZ_WORD;
      OP_LDUB: d.size = SZ_BYTE;
      OP_LDUH: d.size = SZ_HALF;
      OP_LDSB: begin d.size = SZ_BYTE; d.sext = 1'b1; end
      OP_LDSH: begin d.size = SZ_HALF; d.sext = 1'b1; end
      OP_ST:   begin d.size = SZ_WORD; d.store = 1'b1; end
      OP_STB:  begin d.size = SZ_BYTE; d.store = 1'b1; end
      OP_STH:  begin d.size = SZ_HALF; d.store = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // Number of bytes touched by an access of the given size
  function automatic logic [2:0] size_bytes(input size_e s);
    case (s)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Byte-addressed storage: DEPTH x 8 bits, one synchronous write port with four
// byte enables and a combinational four-byte read starting at addr.
// Byte lane 3 (bits 31:24) maps to addr, lane 0 (bits 7:0) to addr+3.
module ram_byte_array #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage is deliberately left without reset so contents survive RESET
  logic [7:0] Mem [DEPTH];

  logic [IW-1:0] idx      [4];
  logic [3:0]    in_range;
  logic [3:0]    wen;

  // Per-lane byte index and bounds check; lanes past the end never wrap
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      in_range[i] = ((32'(addr) + i) < 32'(DEPTH));
      idx[i]      = IW'(32'(addr) + i);
      wen[i]      = be[3-i] & in_range[i];
    end
  end

  // Byte-enabled write
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (wen[i]) begin
        Mem[idx[i]] <= wdata[31-8*i -: 8];
      end
    end
  end

  // Combinational big-endian four-byte read; out-of-range lanes read zero
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (in_range[i]) begin
        rdata[31-8*i -: 8] = Mem[idx[i]];
      end
    end
  end

endmodule

// File: rtl/ram_responder.sv
// RAM responder for a SPARC-style control unit. A request is captured while
// idle, the access is performed LATENCY edges later, and MFC is held until the
// requester drops RAM_enable (four-phase handshake). Handles op3 decode,
// alignment and bounds checks, load extension and byte-lane stores.
module ram_responder
  import sparc_mem_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 512
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        RAM_enable,
  input  logic [5:0]  RAM_OpCode,
  input  logic [8:0]  Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC,
  output logic        MSET
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e      state;
  state_e      next_state;
  logic [3:0]  cnt;

  logic [5:0]  op_q;
  logic [8:0]  addr_q;
  logic [31:0] data_q;

  op_dec_t     dec;
  logic [2:0]  nbytes;
  logic        misaligned;
  logic        out_of_range;
  logic        err;
  logic        capture;
  logic        access;

  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] ld_data;

  assign capture = (state == IDLE) && RAM_enable;
  assign access  = (state == BUSY) && (cnt == 4'd0);

  // Decode and check the captured request
  always_comb begin
    dec          = decode_op3(op_q);
    nbytes       = size_bytes(dec.size);
    misaligned   = ((dec.size == SZ_HALF) && addr_q[0]) ||
                   ((dec.size == SZ_WORD) && (addr_q[1:0] != 2'b00));
    out_of_range = (32'(addr_q) + 32'(nbytes)) > 32'(DEPTH);
    err          = !dec.legal || misaligned || out_of_range;
  end

  // State register
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (RAM_enable) next_state = BUSY;
      BUSY:    if (cnt == 4'd0) next_state = DONE;
      DONE:    if (!RAM_enable) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    MFC = (state == DONE);
  end

  // Latency counter: loaded on capture, counts down while busy
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (capture) begin
      cnt <= CNT_LOAD;
    end else if ((state == BUSY) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Request capture; inputs are ignored until the FSM is idle again
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      op_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (capture) begin
      op_q   <= RAM_OpCode;
      addr_q <= Address;
      data_q <= DataIn;
    end
  end

  // Store lane steering: right-justified store data moves to the top lanes
  always_comb begin
    be    = '0;
    wdata = '0;
    if (access && dec.store && !err) begin
      case (dec.size)
        SZ_BYTE: begin be = 4'b1000; wdata = {data_q[7:0],  24'h0}; end
        SZ_HALF: begin be = 4'b1100; wdata = {data_q[15:0], 16'h0}; end
        default: begin be = 4'b1111; wdata = data_q;               end
      endcase
    end
  end

  // Load extension from the big-endian read word
  always_comb begin
    case (dec.size)
      SZ_BYTE: ld_data = dec.sext ? {{24{rdata[31]}}, rdata[31:24]}
                                  : {24'h0, rdata[31:24]};
      SZ_HALF: ld_data = dec.sext ? {{16{rdata[31]}}, rdata[31:16]}
                                  : {16'h0, rdata[31:16]};
      default: ld_data = rdata;
    endcase
  end

  // Result registers, updated on the access edge and held through DONE
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      DataOut <= '0;
      MSET    <= 1'b0;
    end else if (access) begin
      MSET    <= err;
      DataOut <= (err || dec.store) ? '0 : ld_data;
    end
  end

  ram_byte_array #(
    .DEPTH(DEPTH),
    .AW   (9)
  ) u_mem (
    .clk  (Clk),
    .addr (addr_q),
    .be   (be),
    .wdata(wdata),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_ram_responder.sv
// Directed testbench for ram_responder (LATENCY=2, DEPTH=500).
module tb_ram_responder;
  import sparc_mem_pkg::*;

  logic        Clk = 1'b0;
  logic        RESET;
  logic        RAM_enable;
  logic [5:0]  RAM_OpCode;
  logic [8:0]  Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MFC;
  logic        MSET;

  int vectors     = 0;
  int miscompares = 0;

  ram_responder #(
    .LATENCY(2),
    .DEPTH  (500)
  ) dut (
    .Clk       (Clk),
    .RESET     (RESET),
    .RAM_enable(RAM_enable),
    .RAM_OpCode(RAM_OpCode),
    .Address   (Address),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .MFC       (MFC),
    .MSET      (MSET)
  );

  always #5 Clk = ~Clk;

  // Issue one request, scramble the inputs after capture, and wait (bounded)
  // for MFC. edges = number of rising edges after capture, or -1 on timeout.
  task automatic run_access(input logic [5:0] op, input logic [8:0] addr,
                            input logic [31:0] din, output int edges,
                            output logic [31:0] dout, output logic mset);
    @(negedge Clk);
    RAM_OpCode = op; Address = addr; DataIn = din; RAM_enable = 1'b1;
    @(posedge Clk);
    #1;
    RAM_OpCode = ~op; Address = ~addr; DataIn = ~din;
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk); #1;
      if (MFC === 1'b1) begin edges = i; break; end
    end
    dout = DataOut;
    mset = MSET;
  endtask

  // Drop RAM_enable and report MFC just after the next rising edge
  task automatic release_enable(output logic mfc_after);
    @(negedge Clk);
    RAM_enable = 1'b0;
    @(posedge Clk); #1;
    mfc_after = MFC;
  endtask

  task automatic test_reset();
    RESET = 1'b0; RAM_enable = 1'b0; RAM_OpCode = '0; Address = '0; DataIn = '0;
    repeat (2) @(posedge Clk);
    #1;
    vectors++; if (MFC !== 1'b0) begin miscompares++; $display("FAIL reset_mfc: got %b want 0", MFC); end
    vectors++; if (MSET !== 1'b0) begin miscompares++; $display("FAIL reset_mset: got %b want 0", MSET); end
    vectors++; if (DataOut !== 32'h0) begin miscompares++; $display("FAIL reset_dataout: got %h want 00000000", DataOut); end
    dut.u_mem.Mem[0] = 8'h12; dut.u_mem.Mem[1] = 8'h34;
    dut.u_mem.Mem[2] = 8'h56; dut.u_mem.Mem[3] = 8'h78;
    dut.u_mem.Mem[4] = 8'h80; dut.u_mem.Mem[5] = 8'hF0;
    dut.u_mem.Mem[6] = 8'h00; dut.u_mem.Mem[7] = 8'h00;
    @(negedge Clk);
    RESET = 1'b1;
  endtask

  task automatic test_ld_word();
    int edges; logic [31:0] dout; logic mset; logic mfc;
    run_access(OP_LD, 9'd0, 32'h0, edges, dout, mset);
    vectors++; if (edges !== 2) begin miscompares++; $display("FAIL ld_latency: got %0d want 2", edges); end
    vectors++; if (dout !== 32'h12345678) begin miscompares++; $display("FAIL ld_data: got %h want 12345678", dout); end
    vectors++; if (mset !== 1'b0) begin miscompares++; $display("FAIL ld_mset: got %b want 0", mset); end
    release_enable(mfc);
    vectors++; if (mfc !== 1'b0) begin miscompares++; $display("FAIL ld_mfc_fall: got %b want 0", mfc); end
  endtask

  task automatic test_ld_subword();
    int edges; logic [31:0] dout; logic mset; logic mfc;
    logic [5:0]  ops  [4] = '{OP_LDSB, OP_LDUB, OP_LDSH, OP_LDUH};
    logic [8:0]  adrs [4] = '{9'd5, 9'd5, 9'd4, 9'd4};
    logic [31:0] exps [4] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0, 32'h000080F0};
    for (int i = 0; i < 4; i++) begin
      run_access(ops[i], adrs[i], 32'h0, edges, dout, mset);
      vectors++; if (dout !== exps[i] || mset !== 1'b0) begin miscompares++;
        $display("FAIL ld_subword[%0d]: got %h/%b want %h/0", i, dout, mset, exps[i]); end
      release_enable(mfc);
    end
  endtask

  task automatic test_stores();
    int edges; logic [31:0] dout; logic mset; logic mfc;
    logic [7:0] exp_b [4];
    dut.u_mem.Mem[13] = 8'h3C;
    run_access(OP_STH, 9'd6, 32'h0000ABCD, edges, dout, mset);
    release_enable(mfc);
    vectors++; if (mset !== 1'b0 || dout !== 32'h0) begin miscompares++;
      $display("FAIL sth_status: got %h/%b want 00000000/0", dout, mset); end
    exp_b = '{8'h80, 8'hF0, 8'hAB, 8'hCD};
    for (int i = 0; i < 4; i++) begin
      vectors++; if (dut.u_mem.Mem[4+i] !== exp_b[i]) begin miscompares++;
        $display("FAIL sth_mem[%0d]: got %h want %h", 4+i, dut.u_mem.Mem[4+i], exp_b[i]); end
    end
    run_access(OP_STB, 9'd12, 32'h000000A5, edges, dout, mset);
    release_enable(mfc);
    vectors++; if (dut.u_mem.Mem[12] !== 8'hA5 || dut.u_mem.Mem[13] !== 8'h3C) begin miscompares++;
      $display("FAIL stb_mem: got %h%h want A53C", dut.u_mem.Mem[12], dut.u_mem.Mem[13]); end
    run_access(OP_ST, 9'd16, 32'hCAFEF00D, edges, dout, mset);
    release_enable(mfc);
    exp_b = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    for (int i = 0; i < 4; i++) begin
      vectors++; if (dut.u_mem.Mem[16+i] !== exp_b[i]) begin miscompares++;
        $display("FAIL st_mem[%0d]: got %h want %h", 16+i, dut.u_mem.Mem[16+i], exp_b[i]); end
    end
  endtask

  task automatic test_errors();
    int edges; logic [31:0] dout; logic mset; logic mfc;
    logic [7:0] exp_b [4] = '{8'h56, 8'h78, 8'h80, 8'hF0};
    run_access(OP_ST, 9'd2, 32'h11111111, edges, dout, mset);
    vectors++; if (edges !== 2 || mset !== 1'b1 || dout !== 32'h0) begin miscompares++;
      $display("FAIL st_misaligned: got %0d/%b/%h want 2/1/00000000", edges, mset, dout); end
    release_enable(mfc);
    for (int i = 0; i < 4; i++) begin
      vectors++; if (dut.u_mem.Mem[2+i] !== exp_b[i]) begin miscompares++;
        $display("FAIL st_misaligned_mem[%0d]: got %h want %h", 2+i, dut.u_mem.Mem[2+i], exp_b[i]); end
    end
    run_access(6'b111111, 9'd0, 32'h0, edges, dout, mset);
    vectors++; if (mset !== 1'b1 || dout !== 32'h0) begin miscompares++;
      $display("FAIL illegal_op: got %b/%h want 1/00000000", mset, dout); end
    release_enable(mfc);
    run_access(OP_LDUH, 9'd1, 32'h0, edges, dout, mset);
    vectors++; if (mset !== 1'b1 || dout !== 32'h0) begin miscompares++;
      $display("FAIL half_misaligned: got %b/%h want 1/00000000", mset, dout); end
    release_enable(mfc);
  endtask

  task automatic test_bounds();
    int edges; logic [31:0] dout; logic mset; logic mfc;
    logic [5:0]  ops  [6] = '{OP_LD, OP_LDUB, OP_LDUH, OP_LD, OP_LDUB, OP_LDUH};
    logic [8:0]  adrs [6] = '{9'd496, 9'd499, 9'd498, 9'd500, 9'd500, 9'd500};
    logic [31:0] exps [6] = '{32'h01020304, 32'h00000004, 32'h00000304, 32'h0, 32'h0, 32'h0};
    logic        expm [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    dut.u_mem.Mem[496] = 8'h01; dut.u_mem.Mem[497] = 8'h02;
    dut.u_mem.Mem[498] = 8'h03; dut.u_mem.Mem[499] = 8'h04;
    for (int i = 0; i < 6; i++) begin
      run_access(ops[i], adrs[i], 32'h0, edges, dout, mset);
      vectors++; if (dout !== exps[i] || mset !== expm[i]) begin miscompares++;
        $display("FAIL bounds[%0d]: got %h/%b want %h/%b", i, dout, mset, exps[i], expm[i]); end
      release_enable(mfc);
    end
    run_access(OP_STB, 9'd499, 32'h000000EE, edges, dout, mset);
    release_enable(mfc);
    vectors++; if (mset !== 1'b0 || dut.u_mem.Mem[499] !== 8'hEE) begin miscompares++;
      $display("FAIL stb_last: got %b/%h want 0/ee", mset, dut.u_mem.Mem[499]); end
  endtask

  task automatic test_reset_abort();
    int edges; logic [31:0] dout; logic mset; logic mfc; logic saw;
    logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) dut.u_mem.Mem[8+i] = exp_b[i];
    run_access(OP_LD, 9'd0, 32'h0, edges, dout, mset);
    release_enable(mfc);
    @(negedge Clk);
    RAM_OpCode = OP_ST; Address = 9'd8; DataIn = 32'hDEADBEEF; RAM_enable = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #2;
    RESET = 1'b0;
    #1;
    vectors++; if (DataOut !== 32'h0 || MSET !== 1'b0 || MFC !== 1'b0) begin miscompares++;
      $display("FAIL async_reset: got %h/%b/%b want 00000000/0/0", DataOut, MSET, MFC); end
    RAM_enable = 1'b0;
    saw = 1'b0;
    repeat (3) begin @(posedge Clk); #1; if (MFC !== 1'b0) saw = 1'b1; end
    @(negedge Clk);
    RESET = 1'b1;
    repeat (3) begin @(posedge Clk); #1; if (MFC !== 1'b0) saw = 1'b1; end
    vectors++; if (saw !== 1'b0) begin miscompares++; $display("FAIL abort_no_mfc: got %b want 0", saw); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (dut.u_mem.Mem[8+i] !== exp_b[i]) begin miscompares++;
        $display("FAIL abort_mem[%0d]: got %h want %h", 8+i, dut.u_mem.Mem[8+i], exp_b[i]); end
    end
    run_access(OP_LD, 9'd8, 32'h0, edges, dout, mset);
    vectors++; if (edges !== 2 || dout !== 32'h11223344) begin miscompares++;
      $display("FAIL abort_reload: got %0d/%h want 2/11223344", edges, dout); end
    release_enable(mfc);
  endtask

  task automatic test_back_to_back();
    int edges; logic [31:0] dout; logic mset; logic mfc; int bad;
    run_access(OP_LD, 9'd0, 32'h0, edges, dout, mset);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      Address = 9'd8; RAM_OpCode = OP_ST; DataIn = 32'h0;
      @(posedge Clk); #1;
      if (MFC !== 1'b1 || DataOut !== 32'h12345678) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL hold_done: got %0d bad cycles want 0", bad); end
    vectors++; if (dut.u_mem.Mem[8] !== 8'h11) begin miscompares++;
      $display("FAIL hold_no_second: got %h want 11", dut.u_mem.Mem[8]); end
    release_enable(mfc);
    vectors++; if (mfc !== 1'b0) begin miscompares++; $display("FAIL hold_mfc_fall: got %b want 0", mfc); end
    // enable dropped right after capture: access still completes
    @(negedge Clk);
    RAM_OpCode = OP_LDUB; Address = 9'd1; RAM_enable = 1'b1;
    @(posedge Clk); #1;
    RAM_enable = 1'b0;
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk); #1;
      if (MFC === 1'b1) begin edges = i; break; end
    end
    vectors++; if (edges !== 2 || DataOut !== 32'h00000034) begin miscompares++;
      $display("FAIL drop_busy: got %0d/%h want 2/00000034", edges, DataOut); end
    @(posedge Clk); #1;
    vectors++; if (MFC !== 1'b0) begin miscompares++; $display("FAIL drop_busy_fall: got %b want 0", MFC); end
  endtask

  initial begin
    test_reset();
    test_ld_word();
    test_ld_subword();
    test_stores();
    test_errors();
    test_bounds();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
